if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/rv32i_pkg.sv | 30 +++
 rtl/pc_next_mux.sv | 40 ++++
 rtl/if_stage.sv | 98 +++++++++
 tb/tb_if_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: canonical NOP, fetch-state encoding and
// the default reset vector used by the fetch stage.
package rv32i_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   typedef enum logic [1:0] {
      FS_BOOT = 2'd0,
      FS_RUN  = 2'd1,
      FS_TRAP = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      PC_SEL_RESET    = 2'd0,
      PC_SEL_REDIRECT = 2'd1,
      PC_SEL_HOLD     = 2'd2,
      PC_SEL_SEQ      = 2'd3
   } pc_sel_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-fetch-address selection for the IF stage; holds no state.
// Redirects beat stalls, and TRAP parks the fetch address until a redirect.
module pc_next_mux
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic         rst,
   input  fetch_state_t state,
   input  logic         stall,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_pc,
   input  logic [31:0]  cur_pc,
   output logic [31:0]  next_pc
);

   pc_sel_t sel;

   always_comb begin
      sel = PC_SEL_SEQ;
      if (rst || state == FS_BOOT) begin
         sel = PC_SEL_RESET;
      end else if (redirect_valid) begin
         sel = PC_SEL_REDIRECT;
      end else if (stall || state == FS_TRAP) begin
         sel = PC_SEL_HOLD;
      end
   end

   always_comb begin
      next_pc = cur_pc + PC_STEP;
      case (sel)
         PC_SEL_RESET:    next_pc = RESET_PC;
         PC_SEL_REDIRECT: next_pc = word_align(redirect_pc);
         PC_SEL_HOLD:     next_pc = cur_pc;
         default:         next_pc = cur_pc + PC_STEP;
      endcase
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives a synchronous instruction memory and fills
// the IF/ID pipeline register, handling stalls, redirects and misaligned traps.
module if_stage
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic        if_id_valid,
   output logic        if_id_misaligned
);

   fetch_state_t state;
   logic [31:0]  cur_pc;
   logic         rvalid;
   logic         mis_pend;
   logic [31:0]  mis_pc;

   pc_next_mux #(
      .RESET_PC(RESET_PC)
   ) u_pc_next_mux (
      .rst            (rst),
      .state          (state),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .cur_pc         (cur_pc),
      .next_pc        (imem_addr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= FS_BOOT;
         cur_pc           <= RESET_PC;
         rvalid           <= 1'b0;
         mis_pend         <= 1'b0;
         mis_pc           <= RESET_PC;
         if_id_instr      <= NOP_INSTR;
         if_id_pc         <= RESET_PC;
         if_id_valid      <= 1'b0;
         if_id_misaligned <= 1'b0;
      end else begin
         // cur_pc always tracks the address whose word arrives next cycle.
         cur_pc <= imem_addr;
         case (state)
            FS_BOOT: begin
               rvalid           <= 1'b1;
               state            <= FS_RUN;
               mis_pend         <= 1'b0;
               if_id_instr      <= imem_rdata;
               if_id_pc         <= cur_pc;
               if_id_valid      <= 1'b0;
               if_id_misaligned <= 1'b0;
            end
            default: begin
               if (redirect_valid) begin
                  if_id_instr      <= NOP_INSTR;
                  if_id_valid      <= 1'b0;
                  if_id_misaligned <= 1'b0;
                  if (is_misaligned(redirect_pc)) begin
                     state    <= FS_TRAP;
                     mis_pend <= 1'b1;
                     mis_pc   <= redirect_pc;
                  end else begin
                     state    <= FS_RUN;
                     mis_pend <= 1'b0;
                  end
               end else if (!stall) begin
                  if (state == FS_TRAP) begin
                     // One exception entry carrying the faulting target, then bubbles.
                     if_id_instr      <= NOP_INSTR;
                     if_id_valid      <= mis_pend;
                     if_id_misaligned <= mis_pend;
                     if (mis_pend) begin
                        if_id_pc <= mis_pc;
                     end
                     mis_pend <= 1'b0;
                  end else begin
                     if_id_instr      <= imem_rdata;
                     if_id_pc         <= cur_pc;
                     if_id_valid      <= rvalid;
                     if_id_misaligned <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Randomised scoreboard bench for if_stage: a program-order fetch model feeds
// expected IF/ID entries; a negedge monitor pops and compares them.
module tb_if_stage;
   import rv32i_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic        if_id_valid;
   logic        if_id_misaligned;

   always #5 clk = ~clk;

   if_stage #(
      .RESET_PC(RPC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_addr        (imem_addr),
      .imem_rdata       (imem_rdata),
      .stall            (stall),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .if_id_instr      (if_id_instr),
      .if_id_pc         (if_id_pc),
      .if_id_valid      (if_id_valid),
      .if_id_misaligned (if_id_misaligned)
   );

   // Synchronous instruction memory, reading NOP while reset is held.
   logic [31:0] mem [0:1023];
   logic [31:0] rdata_q;
   always @(posedge clk) rdata_q <= mem[imem_addr[11:2]];
   assign imem_rdata = rst ? NOP_INSTR : rdata_q;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        mis;
   } entry_t;

   entry_t sb[$];
   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural fetch stream, not the pipeline structure.
   bit          m_boot = 1'b1;
   bit          m_trap = 1'b0;
   bit          m_pend = 1'b0;
   logic [31:0] m_next = RPC;
   logic [31:0] m_pend_pc = 32'h0;
   logic [31:0] m_last = RPC;

   task automatic cycle(input bit r_rst, input bit s, input bit r, input logic [31:0] t);
      logic [31:0] exp_addr;
      entry_t e;
      @(negedge clk);
      #2;
      rst            = r_rst;
      stall          = s;
      redirect_valid = r;
      redirect_pc    = t;
      if (r_rst) begin
         sb.delete();
         m_boot   = 1'b1;
         m_trap   = 1'b0;
         m_pend   = 1'b0;
         exp_addr = RPC;
      end else if (m_boot) begin
         m_boot   = 1'b0;
         m_next   = RPC;
         exp_addr = RPC;
      end else if (r) begin
         exp_addr = {t[31:2], 2'b00};
         if (t[1:0] != 2'b00) begin
            m_trap    = 1'b1;
            m_pend    = 1'b1;
            m_pend_pc = t;
         end else begin
            m_trap = 1'b0;
            m_pend = 1'b0;
            m_next = exp_addr;
         end
      end else if (m_trap) begin
         exp_addr = m_last;
         if (!s && m_pend) begin
            e.pc    = m_pend_pc;
            e.instr = NOP_INSTR;
            e.mis   = 1'b1;
            sb.push_back(e);
            m_pend  = 1'b0;
         end
      end else if (s) begin
         exp_addr = m_next;
      end else begin
         e.pc    = m_next;
         e.instr = mem[m_next[11:2]];
         e.mis   = 1'b0;
         sb.push_back(e);
         m_next   = m_next + 32'd4;
         exp_addr = m_next;
      end
      m_last = exp_addr;
      #1;
      chk("imem_addr", imem_addr, exp_addr);
   endtask

   // What the cycle ending at the last posedge looked like.
   logic s_q = 1'b0;
   logic r_q = 1'b0;
   logic rst_q = 1'b1;
   logic rst_qq = 1'b1;
   always @(posedge clk) begin
      s_q    <= stall;
      r_q    <= redirect_valid;
      rst_q  <= rst;
      rst_qq <= rst_q;
   end

   logic [31:0] p_instr = NOP_INSTR;
   logic [31:0] p_pc = RPC;
   logic        p_valid = 1'b0;
   logic        p_mis = 1'b0;

   always @(negedge clk) begin
      entry_t e;
      if (rst_q) begin
         chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
         chk("rst_instr", if_id_instr, NOP_INSTR);
         chk("rst_pc", if_id_pc, RPC);
         chk("rst_mis", {31'd0, if_id_misaligned}, 32'd0);
      end else if (rst_qq) begin
         chk("boot_valid", {31'd0, if_id_valid}, 32'd0);
      end else if (s_q && !r_q) begin
         chk("hold_instr", if_id_instr, p_instr);
         chk("hold_pc", if_id_pc, p_pc);
         chk("hold_valid", {31'd0, if_id_valid}, {31'd0, p_valid});
         chk("hold_mis", {31'd0, if_id_misaligned}, {31'd0, p_mis});
      end else if (if_id_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_entry: got pc %h instr %h, expected no entry", if_id_pc, if_id_instr);
         end else begin
            e = sb.pop_front();
            $display("entry pc=%h instr=%h mis=%0b", if_id_pc, if_id_instr, if_id_misaligned);
            chk("entry_pc", if_id_pc, e.pc);
            chk("entry_instr", if_id_instr, e.instr);
            chk("entry_mis", {31'd0, if_id_misaligned}, {31'd0, e.mis});
         end
      end
      p_instr = if_id_instr;
      p_pc    = if_id_pc;
      p_valid = if_id_valid;
      p_mis   = if_id_misaligned;
   end

   initial begin
      logic [31:0] t;
      bit s, r, rr;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;

      repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      // Reset release and in-order start, then a 3-cycle stall holding pc 0x8.
      repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 32'h40);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 32'h80);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 32'h42);
      repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 32'h100);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
      repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      // Misaligned trap with a stalled pending entry, then reset from TRAP.
      cycle(1'b0, 1'b0, 1'b1, 32'h203);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'h0);

      for (int n = 0; n < 800; n++) begin
         rr = ($urandom_range(0, 99) == 0);
         s  = ($urandom_range(0, 3) == 0);
         r  = ($urandom_range(0, 11) == 0);
         t  = $urandom & 32'h0000_0FFF;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         cycle(rr, s, r, t);
      end

      repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      #3;
      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
